// File: rtl/pht_update_scheduler_if.sv
// Bundle between commit/rollback logic, the pattern-history table and the update scheduler.
interface pht_update_scheduler_if #(
    parameter int INDEX_WIDTH   = 10,
    parameter int COUNTER_WIDTH = 2,
    parameter int FIFO_DEPTH    = 4
);
    localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic                     PL_stall;
    logic                     flush;
    logic                     upd_valid;
    logic [INDEX_WIDTH-1:0]   upd_index;
    logic                     upd_taken;
    logic                     upd_ready;
    logic                     rb_valid;
    logic [INDEX_WIDTH-1:0]   rb_index;
    logic [COUNTER_WIDTH-1:0] rb_count;
    logic [INDEX_WIDTH-1:0]   pht_rd_index;
    logic [COUNTER_WIDTH-1:0] pht_rd_count;
    logic                     pht_we;
    logic [INDEX_WIDTH-1:0]   pht_wr_index;
    logic [COUNTER_WIDTH-1:0] pht_wr_count;
    logic                     init_done;
    logic [LEVEL_WIDTH-1:0]   fifo_level;

    modport slave (
        input  PL_stall, flush, upd_valid, upd_index, upd_taken,
               rb_valid, rb_index, rb_count, pht_rd_count,
        output upd_ready, pht_rd_index, pht_we, pht_wr_index, pht_wr_count,
               init_done, fifo_level
    );

    modport master (
        output PL_stall, flush, upd_valid, upd_index, upd_taken,
               rb_valid, rb_index, rb_count, pht_rd_count,
        input  upd_ready, pht_rd_index, pht_we, pht_wr_index, pht_wr_count,
               init_done, fifo_level
    );
endinterface

// File: rtl/pht_update_scheduler.sv
// Queues commit-time PHT counter updates and serialises them with rollback restores on one write port.
// Define PHT_INIT_SWEEP_EN to add the post-reset sweep that writes INIT_VALUE to every entry.
module pht_update_scheduler #(
    parameter int INDEX_WIDTH   = 10,
    parameter int COUNTER_WIDTH = 2,
    parameter int INIT_VALUE    = 0,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pht_update_scheduler_if.slave bus
);
    localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_WIDTH = PTR_WIDTH + 1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [LEVEL_WIDTH-1:0]   LEVEL_FULL = LEVEL_WIDTH'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (INIT_VALUE < 0 || INIT_VALUE >= (1 << COUNTER_WIDTH)) begin : g_bad_init
        $error("INIT_VALUE does not fit in COUNTER_WIDTH");
    end

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] index;
        logic                   taken;
    } upd_entry_t;

    state_t                   state;
    logic                     init_done_q;
    upd_entry_t               fifo_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]     wr_ptr, rd_ptr;
    logic [LEVEL_WIDTH-1:0]   level;
    upd_entry_t               head;
    logic                     run, empty, push, pop, rb_wr;
    logic [COUNTER_WIDTH-1:0] upd_count;

    assign run   = (state == RUN);
    assign empty = (level == '0);
    assign head  = fifo_mem[rd_ptr];
    assign push  = bus.upd_valid && bus.upd_ready && !bus.flush;
    // Rollback owns the write port, so the queue holds its head for that cycle.
    assign rb_wr = run && bus.rb_valid;
    assign pop   = run && !bus.rb_valid && !empty && !bus.PL_stall;

    assign bus.upd_ready    = run && (level < LEVEL_FULL);
    assign bus.pht_rd_index = head.index;
    assign bus.fifo_level   = level;
    assign bus.init_done    = init_done_q;

    always_comb begin
        upd_count = bus.pht_rd_count;
        if (head.taken) begin
            if (bus.pht_rd_count != CNT_MAX) upd_count = bus.pht_rd_count + 1'b1;
        end else begin
            if (bus.pht_rd_count != '0) upd_count = bus.pht_rd_count - 1'b1;
        end
    end

`ifdef PHT_INIT_SWEEP_EN
    localparam logic [COUNTER_WIDTH-1:0] CNT_INIT = COUNTER_WIDTH'(INIT_VALUE);

    logic [INDEX_WIDTH-1:0] sweep_idx;
    logic                   sweep_on;

    // sweep_on is registered so nothing is written while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            sweep_idx   <= '0;
            sweep_on    <= 1'b0;
            init_done_q <= 1'b0;
        end else if (state == INIT) begin
            sweep_on <= 1'b1;
            if (sweep_on) begin
                sweep_idx <= sweep_idx + 1'b1;
                if (sweep_idx == '1) begin
                    state       <= RUN;
                    sweep_on    <= 1'b0;
                    init_done_q <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            init_done_q <= 1'b0;
        end else begin
            state       <= RUN;
            init_done_q <= 1'b1;
        end
    end
`endif

    always_comb begin
        bus.pht_we       = 1'b0;
        bus.pht_wr_index = head.index;
        bus.pht_wr_count = upd_count;
`ifdef PHT_INIT_SWEEP_EN
        if (sweep_on) begin
            bus.pht_we       = 1'b1;
            bus.pht_wr_index = sweep_idx;
            bus.pht_wr_count = CNT_INIT;
        end else
`endif
        if (rb_wr) begin
            bus.pht_we       = 1'b1;
            bus.pht_wr_index = bus.rb_index;
            bus.pht_wr_count = bus.rb_count;
        end else if (pop) begin
            bus.pht_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {bus.upd_index, bus.upd_taken};
    end

    // Flush drops the queue but the write chosen this cycle still goes out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (run && bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(pop);
        end
    end
endmodule
